// File: rtl/dcache_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcache_port_ctrl_if
// Bundles every signal of one L1 data-cache port controller: the core request
// port, the shared tag-compare/SRAM arbiter port and the miss-unit port.
//   modport slave  : the port controller (drives the *_o signals)
//   modport master : the environment around it (core, arbiter, miss unit)
// Signal names keep their _i/_o suffixes as seen from the controller, so the
// same name means the same wire on both sides.
// -----------------------------------------------------------------------------
interface dcache_port_ctrl_if #(
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128
);
   // core side
   logic                              bypass_i;
   logic                              stall_i;
   logic                              busy_o;
   logic                              req_i;
   logic                              kill_i;
   logic [INDEX_WIDTH-1:0]            addr_index_i;
   logic [TAG_WIDTH-1:0]              addr_tag_i;
   logic                              tag_valid_i;
   logic                              we_i;
   logic [7:0]                        be_i;
   logic [63:0]                       wdata_i;
   logic [1:0]                        size_i;
   logic                              gnt_o;
   logic                              rvalid_o;
   logic [63:0]                       rdata_o;
   // tag-compare / SRAM arbiter side
   logic [SET_ASSOC-1:0]              req_o;
   logic [INDEX_WIDTH-1:0]            addr_o;
   logic                              we_o;
   logic [LINE_WIDTH/8-1:0]           be_o;
   logic [LINE_WIDTH-1:0]             wdata_o;
   logic                              dirty_o;
   logic                              gnt_i;
   logic [SET_ASSOC*LINE_WIDTH-1:0]   data_i;
   logic [SET_ASSOC-1:0]              hit_way_i;
   logic [TAG_WIDTH-1:0]              tag_o;
   // miss unit side
   logic                              miss_req_valid_o;
   logic                              miss_bypass_o;
   logic [TAG_WIDTH+INDEX_WIDTH-1:0]  miss_addr_o;
   logic                              miss_gnt_i;
   logic                              bypass_gnt_i;
   logic [63:0]                       critical_word_i;
   logic                              critical_word_valid_i;
   logic [63:0]                       bypass_data_i;
   logic                              bypass_valid_i;
   logic [TAG_WIDTH+INDEX_WIDTH-1:0]  mshr_addr_o;
   logic                              mshr_addr_matches_i;
   logic                              mshr_index_matches_i;

   modport slave (
      input  bypass_i, stall_i, req_i, kill_i, addr_index_i, addr_tag_i, tag_valid_i,
             we_i, be_i, wdata_i, size_i, gnt_i, data_i, hit_way_i, miss_gnt_i,
             bypass_gnt_i, critical_word_i, critical_word_valid_i, bypass_data_i,
             bypass_valid_i, mshr_addr_matches_i, mshr_index_matches_i,
      output busy_o, gnt_o, rvalid_o, rdata_o, req_o, addr_o, we_o, be_o, wdata_o,
             dirty_o, tag_o, miss_req_valid_o, miss_bypass_o, miss_addr_o, mshr_addr_o
   );

   modport master (
      output bypass_i, stall_i, req_i, kill_i, addr_index_i, addr_tag_i, tag_valid_i,
             we_i, be_i, wdata_i, size_i, gnt_i, data_i, hit_way_i, miss_gnt_i,
             bypass_gnt_i, critical_word_i, critical_word_valid_i, bypass_data_i,
             bypass_valid_i, mshr_addr_matches_i, mshr_index_matches_i,
      input  busy_o, gnt_o, rvalid_o, rdata_o, req_o, addr_o, we_o, be_o, wdata_o,
             dirty_o, tag_o, miss_req_valid_o, miss_bypass_o, miss_addr_o, mshr_addr_o
   );
endinterface

// File: rtl/dcache_port_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_port_ctrl
// Per-port controller of the non-blocking set-associative L1 data cache.
// Sequences one core request at a time: index lookup, tag check, then either
// a hit read/write on the arrays or a hand-off to the miss unit (cacheable
// miss or uncached bypass access).
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (aborts any request, no response)
//   bus    : dcache_port_ctrl_if.slave -- core, arbiter and miss-unit signals
// -----------------------------------------------------------------------------
module dcache_port_ctrl #(
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128
) (
   input logic                clk_i,
   input logic                rst_i,
   dcache_port_ctrl_if.slave  bus
);
   localparam int WORDS  = LINE_WIDTH / 64;
   localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WAY_W  = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_TAG,
      STORE_REQ,
      WAIT_MSHR,
      REISSUE,
      MISS_REQ,
      WAIT_CRITICAL,
      BYPASS_REQ,
      BYPASS_WAIT
   } state_e;

   state_e                  state_q, state_d;

   // request registers, captured at grant time
   logic [INDEX_WIDTH-1:0]  index_q;
   logic                    we_q;
   logic [7:0]              be_q;
   logic [63:0]             wdata_q;
   logic [1:0]              size_q;
   // tag arrives a cycle after grant; tag_valid_q stays set across a re-lookup
   logic [TAG_WIDTH-1:0]    tag_q;
   logic                    tag_valid_q;
   // way to write on a store hit (hit_way_i is only valid in the compare cycle)
   logic [SET_ASSOC-1:0]    hit_oh_q;

   logic                    latch_req, latch_tag, latch_hit;

   // hit decode: multi-hit resolves to the lowest way
   logic                    hit_any;
   logic [WAY_W-1:0]        hit_idx;
   logic [SET_ASSOC-1:0]    hit_oh;
   logic [LINE_WIDTH-1:0]   hit_line;
   logic [63:0]             hit_word;
   logic [WSEL_W-1:0]       word_sel;
   logic [LINE_WIDTH/8-1:0] be_line;

   // size is captured with the request but not needed for line-level access
   logic                    unused_size;
   assign unused_size = ^size_q;

   // 64-bit word slot inside the line: addr[BYTE_OFFSET-1:3]
   if (WORDS > 1) begin : g_word_sel
      assign word_sel = index_q[3 +: WSEL_W];
   end else begin : g_single_word
      assign word_sel = '0;
   end

   always_comb begin
      hit_any = |bus.hit_way_i;
      hit_idx = '0;
      for (int w = SET_ASSOC - 1; w >= 0; w--) begin
         if (bus.hit_way_i[w]) hit_idx = WAY_W'(w);
      end
      hit_oh = '0;
      if (hit_any) hit_oh[hit_idx] = 1'b1;
      hit_line = bus.data_i[int'(hit_idx) * LINE_WIDTH +: LINE_WIDTH];
      hit_word = hit_line[int'(word_sel) * 64 +: 64];
      be_line  = '0;
      be_line[int'(word_sel) * 8 +: 8] = be_q;
   end

   // Next-state and output logic.
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d              = state_q;
      latch_req            = 1'b0;
      latch_tag            = 1'b0;
      latch_hit            = 1'b0;
      bus.gnt_o            = 1'b0;
      bus.rvalid_o         = 1'b0;
      bus.rdata_o          = '0;
      bus.req_o            = '0;
      bus.addr_o           = '0;
      bus.we_o             = 1'b0;
      bus.be_o             = '0;
      bus.wdata_o          = '0;
      bus.dirty_o          = 1'b0;
      bus.miss_req_valid_o = 1'b0;
      bus.miss_bypass_o    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_i && !bus.stall_i && !bus.mshr_index_matches_i) begin
               bus.req_o  = '1;
               bus.addr_o = bus.addr_index_i;
               bus.gnt_o  = bus.gnt_i;
               if (bus.gnt_i) begin
                  latch_req = 1'b1;
                  state_d   = WAIT_TAG;
               end
            end
         end

         WAIT_TAG: begin
            if (bus.kill_i && !we_q) begin
               state_d = IDLE;
            end else if (!tag_valid_q) begin
               latch_tag = bus.tag_valid_i;
            end else if (bus.bypass_i) begin
               state_d = BYPASS_REQ;
            end else if (hit_any) begin
               if (we_q) begin
                  latch_hit = 1'b1;
                  state_d   = STORE_REQ;
               end else begin
                  bus.rvalid_o = 1'b1;
                  bus.rdata_o  = hit_word;
                  state_d      = IDLE;
               end
            end else if (bus.mshr_addr_matches_i) begin
               state_d = WAIT_MSHR;
            end else begin
               state_d = MISS_REQ;
            end
         end

         STORE_REQ: begin
            bus.req_o   = hit_oh_q;
            bus.we_o    = 1'b1;
            bus.dirty_o = 1'b1;
            bus.addr_o  = index_q;
            bus.wdata_o = {WORDS{wdata_q}};
            bus.be_o    = be_line;
            if (bus.gnt_i) state_d = IDLE;
         end

         WAIT_MSHR: begin
            if (!bus.mshr_addr_matches_i) state_d = REISSUE;
         end

         // re-lookup of the latched index; the tag is kept, so the compare
         // happens in the first WAIT_TAG cycle after the grant
         REISSUE: begin
            bus.req_o  = '1;
            bus.addr_o = index_q;
            if (bus.gnt_i) state_d = WAIT_TAG;
         end

         MISS_REQ: begin
            bus.miss_req_valid_o = 1'b1;
            if (bus.miss_gnt_i) state_d = we_q ? REISSUE : WAIT_CRITICAL;
         end

         WAIT_CRITICAL: begin
            if (bus.critical_word_valid_i) begin
               bus.rvalid_o = 1'b1;
               bus.rdata_o  = bus.critical_word_i;
               state_d      = IDLE;
            end
         end

         BYPASS_REQ: begin
            bus.miss_req_valid_o = 1'b1;
            bus.miss_bypass_o    = 1'b1;
            if (bus.bypass_gnt_i) state_d = we_q ? IDLE : BYPASS_WAIT;
         end

         BYPASS_WAIT: begin
            if (bus.bypass_valid_i) begin
               bus.rvalid_o = 1'b1;
               bus.rdata_o  = bus.bypass_data_i;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o      = (state_q != IDLE);
   assign bus.tag_o       = tag_q;
   assign bus.miss_addr_o = {tag_q, index_q};
   assign bus.mshr_addr_o = (state_q == IDLE) ? {bus.addr_tag_i, bus.addr_index_i}
                                              : {tag_q, index_q};

   // NOTE: state and request registers use non-blocking assignments so every
   // flop samples the values from before the edge, independent of block order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         index_q     <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
         hit_oh_q    <= '0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            index_q     <= bus.addr_index_i;
            we_q        <= bus.we_i;
            be_q        <= bus.be_i;
            wdata_q     <= bus.wdata_i;
            size_q      <= bus.size_i;
            tag_valid_q <= 1'b0;
         end
         if (latch_tag) begin
            tag_q       <= bus.addr_tag_i;
            tag_valid_q <= 1'b1;
         end
         if (latch_hit) hit_oh_q <= hit_oh;
      end
   end
endmodule

// File: tb/tb_dcache_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_port_ctrl
// Self-checking bench for dcache_port_ctrl. Load results are predicted when a
// load is issued (pushed to exp_q) and compared when rvalid_o fires; array and
// miss-unit fields are checked directly in the cycle they are expected.
// -----------------------------------------------------------------------------
module tb_dcache_port_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   dcache_port_ctrl_if bus ();

   dcache_port_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int          n_cmp   = 0;
   int          n_err   = 0;
   int          rv_cnt  = 0;
   int          we_cnt  = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // response monitor: every rvalid_o must match the oldest predicted load
   always @(negedge clk) begin
      if (!rst && bus.rvalid_o === 1'b1) begin
         rv_cnt++;
         if (exp_q.size() == 0) check("rvalid without pending load", bus.rvalid_o, 1'b0);
         else check("rdata", bus.rdata_o, exp_q.pop_front());
      end
      if (!rst && bus.we_o === 1'b1) we_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int way, input int word, input logic [63:0] val);
      bus.data_i[way * 128 + word * 64 +: 64] = val;
   endtask

   // cycle 0: request + grant; cycle 1: tag; returns at the start of cycle 2,
   // the WAIT_TAG cycle in which the tag compare result is consumed
   task automatic issue(input logic we, input logic [11:0] idx, input logic [43:0] tag,
                        input logic [7:0] be, input logic [63:0] wd);
      bus.req_i        = 1'b1;
      bus.we_i         = we;
      bus.addr_index_i = idx;
      bus.addr_tag_i   = 44'h0;
      bus.be_i         = be;
      bus.wdata_i      = wd;
      bus.size_i       = 2'd3;
      bus.gnt_i        = 1'b1;
      @(negedge clk);
      check("gnt_o on grant", bus.gnt_o, 1'b1);
      check("lookup addr_o", bus.addr_o, idx);
      tick();
      bus.req_i       = 1'b0;
      bus.gnt_i       = 1'b0;
      bus.addr_tag_i  = tag;
      bus.tag_valid_i = 1'b1;
      tick();
      bus.tag_valid_i = 1'b0;
      bus.addr_tag_i  = 44'h0;
   endtask

   // bounded wait for miss_req_valid_o; ends at the negedge where it is seen
   task automatic wait_miss_req(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         if (bus.miss_req_valid_o === 1'b1) seen = 1'b1;
         else tick();
      end
      check({tag, " miss_req_valid seen"}, seen, 1'b1);
   endtask

   initial begin
      int we_before;
      bus.bypass_i = 0; bus.stall_i = 0; bus.req_i = 0; bus.kill_i = 0;
      bus.addr_index_i = '0; bus.addr_tag_i = '0; bus.tag_valid_i = 0;
      bus.we_i = 0; bus.be_i = '0; bus.wdata_i = '0; bus.size_i = '0;
      bus.gnt_i = 0; bus.data_i = '0; bus.hit_way_i = '0;
      bus.miss_gnt_i = 0; bus.bypass_gnt_i = 0;
      bus.critical_word_i = '0; bus.critical_word_valid_i = 0;
      bus.bypass_data_i = '0; bus.bypass_valid_i = 0;
      bus.mshr_addr_matches_i = 0; bus.mshr_index_matches_i = 0;

      // ---------------- reset state ----------------
      @(negedge clk);
      check("reset busy_o", bus.busy_o, 1'b0);
      check("reset gnt_o", bus.gnt_o, 1'b0);
      check("reset rvalid_o", bus.rvalid_o, 1'b0);
      check("reset req_o", bus.req_o, 8'h00);
      check("reset miss_req_valid_o", bus.miss_req_valid_o, 1'b0);
      check("reset tag_o", bus.tag_o, 44'h0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // line contents: way 3 word0/word1, way 5 word0, way 1 word0
      set_word(3, 0, 64'hBEEF);
      set_word(3, 1, 64'hDEAD);
      set_word(5, 0, 64'h0BAD);
      set_word(1, 0, 64'h1234);

      // ---------------- load hit, word 1 ----------------
      issue(1'b0, 12'h048, 44'h12, 8'h00, 64'h0);
      bus.hit_way_i = 8'b0000_1000;
      exp_q.push_back(64'hDEAD);
      @(negedge clk);
      check("load hit rvalid two cycles after gnt", bus.rvalid_o, 1'b1);
      check("tag_o latched", bus.tag_o, 44'h12);
      tick();
      bus.hit_way_i = '0;
      @(negedge clk);
      check("load hit back to idle", bus.busy_o, 1'b0);
      tick();

      // ---------------- multi-hit load, word 0, lowest way wins ----------------
      issue(1'b0, 12'h040, 44'h12, 8'h00, 64'h0);
      bus.hit_way_i = 8'b1010_1000;
      exp_q.push_back(64'hBEEF);
      tick();
      bus.hit_way_i = '0;

      // ---------------- store hit ----------------
      we_before = we_cnt;
      issue(1'b1, 12'h048, 44'h21, 8'h0F, 64'h11223344);
      bus.hit_way_i = 8'b0000_0100;
      tick();
      bus.hit_way_i = '0;
      @(negedge clk);
      check("store req_o hit way", bus.req_o, 8'h04);
      check("store we_o", bus.we_o, 1'b1);
      check("store dirty_o", bus.dirty_o, 1'b1);
      check("store addr_o", bus.addr_o, 12'h048);
      check("store be_o slot 1", bus.be_o, 16'h0F00);
      check("store wdata_o replicated", bus.wdata_o, {2{64'h11223344}});
      tick();
      bus.gnt_i = 1'b1;
      @(negedge clk);
      check("store held until gnt", bus.we_o, 1'b1);
      tick();
      bus.gnt_i = 1'b0;
      @(negedge clk);
      check("store done idle", bus.busy_o, 1'b0);
      check("store array writes", we_cnt - we_before, 2);
      tick();

      // ---------------- load miss ----------------
      issue(1'b0, 12'h100, 44'h77, 8'h00, 64'h0);
      bus.hit_way_i = '0;
      wait_miss_req("load miss");
      check("load miss not bypass", bus.miss_bypass_o, 1'b0);
      check("load miss addr", bus.miss_addr_o, {44'h77, 12'h100});
      tick();
      @(negedge clk);
      check("miss req held without gnt", bus.miss_req_valid_o, 1'b1);
      check("miss addr stable", bus.miss_addr_o, {44'h77, 12'h100});
      tick();
      bus.miss_gnt_i = 1'b1;
      tick();
      bus.miss_gnt_i = 1'b0;
      @(negedge clk);
      check("miss req dropped after gnt", bus.miss_req_valid_o, 1'b0);
      tick();
      bus.critical_word_i       = 64'hCAFE;
      bus.critical_word_valid_i = 1'b1;
      exp_q.push_back(64'hCAFE);
      tick();
      bus.critical_word_valid_i = 1'b0;

      // ---------------- store miss -> reissue -> store hit ----------------
      issue(1'b1, 12'h0C8, 44'h99, 8'hF0, 64'hA5);
      bus.hit_way_i = '0;
      wait_miss_req("store miss");
      bus.miss_gnt_i = 1'b1;
      tick();
      bus.miss_gnt_i = 1'b0;
      bus.gnt_i      = 1'b1;
      @(negedge clk);
      check("reissue req_o all ways", bus.req_o, 8'hFF);
      check("reissue addr_o", bus.addr_o, 12'h0C8);
      tick();
      bus.gnt_i     = 1'b0;
      bus.hit_way_i = 8'h80;
      tick();
      bus.hit_way_i = '0;
      bus.gnt_i     = 1'b1;
      @(negedge clk);
      check("store after refill req_o", bus.req_o, 8'h80);
      check("store after refill be_o", bus.be_o, 16'hF000);
      tick();
      bus.gnt_i = 1'b0;

      // ---------------- bypass load ----------------
      we_before    = we_cnt;
      bus.bypass_i = 1'b1;
      issue(1'b0, 12'h010, 44'h05, 8'h00, 64'h0);
      bus.hit_way_i = 8'h01;
      wait_miss_req("bypass");
      check("bypass miss_bypass_o", bus.miss_bypass_o, 1'b1);
      bus.hit_way_i    = '0;
      bus.bypass_gnt_i = 1'b1;
      tick();
      bus.bypass_gnt_i = 1'b0;
      tick();
      bus.bypass_data_i  = 64'h55;
      bus.bypass_valid_i = 1'b1;
      exp_q.push_back(64'h55);
      tick();
      bus.bypass_valid_i = 1'b0;
      bus.bypass_i       = 1'b0;
      @(negedge clk);
      check("bypass no array write", we_cnt - we_before, 0);
      tick();

      // ---------------- MSHR collision ----------------
      bus.mshr_addr_matches_i = 1'b1;
      issue(1'b0, 12'h200, 44'h33, 8'h00, 64'h0);
      bus.hit_way_i = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no miss req during mshr match", bus.miss_req_valid_o, 1'b0);
         tick();
      end
      @(negedge clk);
      check("mshr_addr_o latched", bus.mshr_addr_o, {44'h33, 12'h200});
      tick();
      bus.mshr_addr_matches_i = 1'b0;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_o === 8'hFF) seen = 1'b1;
            else tick();
         end
         check("mshr relookup issued", seen, 1'b1);
      end
      check("mshr relookup addr_o", bus.addr_o, 12'h200);
      tick();
      bus.gnt_i = 1'b1;
      tick();
      bus.gnt_i     = 1'b0;
      bus.hit_way_i = 8'h02;
      exp_q.push_back(64'h1234);
      tick();
      bus.hit_way_i = '0;

      // ---------------- kill in WAIT_TAG ----------------
      issue(1'b0, 12'h300, 44'h44, 8'h00, 64'h0);
      bus.kill_i    = 1'b1;
      bus.hit_way_i = 8'h01;
      tick();
      bus.kill_i    = 1'b0;
      bus.hit_way_i = '0;
      @(negedge clk);
      check("kill back to idle", bus.busy_o, 1'b0);
      tick();

      // ---------------- stall and index collision block grants ----------------
      bus.req_i   = 1'b1;
      bus.gnt_i   = 1'b1;
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall gnt_o", bus.gnt_o, 1'b0);
         check("stall req_o", bus.req_o, 8'h00);
         tick();
      end
      bus.stall_i              = 1'b0;
      bus.mshr_index_matches_i = 1'b1;
      @(negedge clk);
      check("index collision gnt_o", bus.gnt_o, 1'b0);
      tick();
      bus.mshr_index_matches_i = 1'b0;
      bus.req_i                = 1'b0;
      bus.gnt_i                = 1'b0;
      @(negedge clk);
      check("stall leaves idle", bus.busy_o, 1'b0);
      tick();

      // ---------------- reset mid-operation ----------------
      issue(1'b0, 12'h180, 44'h66, 8'h00, 64'h0);
      wait_miss_req("reset test");
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("async reset busy_o", bus.busy_o, 1'b0);
      check("async reset miss_req_valid_o", bus.miss_req_valid_o, 1'b0);
      tick();
      rst = 1'b0;
      bus.critical_word_i       = 64'hFFFF;
      bus.critical_word_valid_i = 1'b1;
      tick();
      bus.critical_word_valid_i = 1'b0;
      repeat (2) tick();

      // ---------------- end of run ----------------
      check("all predicted loads returned", exp_q.size(), 0);
      check("rvalid pulse count", rv_cnt, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
